// File: rtl/multi_ch_frame_serializer.sv
// Multi-lane parallel-to-serial frame transmitter with a one-word
// holding buffer, configurable bit order, inter-frame gap and pause.
module multi_ch_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_BITS   = 0
) (
  input  logic                         serclk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] par_data_in,
  input  logic                         par_valid_in,
  output logic                         par_ready_out,
  output logic [NUM_CH-1:0]            s_out,
  output logic                         s_load_out,
  output logic                         s_busy_out
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GC = $clog2(GAP_BITS + 1);
  localparam int GW = (GC > 1) ? GC : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GLAST =
    GW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t                         state;
  logic [NUM_CH*DATA_WIDTH-1:0]   hold;
  logic                           buf_full;
  logic [DATA_WIDTH-1:0]          sh [NUM_CH];
  logic [BW-1:0]                  bit_cnt;
  logic [GW-1:0]                  gap_cnt;
  logic                           load;
  logic                           last_bit;
  logic                           gap_done;

  assign last_bit = (bit_cnt == LAST);
  assign gap_done = (gap_cnt == GLAST);

  // Back-to-back reload only skips the gap when there is no gap.
  always_comb begin
    load = 1'b0;
    if (enable && buf_full) begin
      unique case (state)
        IDLE:    load = 1'b1;
        GAP:     load = gap_done;
        SHIFT:   load = last_bit && (GAP_BITS == 0);
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge serclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold     <= '0;
      buf_full <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sh[c] <= '0;
      end
    end else begin
      if (par_valid_in && !buf_full) begin
        hold     <= par_data_in;
        buf_full <= 1'b1;
      end
      if (load) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sh[c] <= hold[c*DATA_WIDTH +: DATA_WIDTH];
        end
        bit_cnt  <= '0;
        buf_full <= 1'b0;
        state    <= SHIFT;
      end else if (enable) begin
        unique case (state)
          SHIFT: begin
            if (last_bit) begin
              if (GAP_BITS > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              for (int c = 0; c < NUM_CH; c++) begin
                if (LSB_FIRST != 0) begin
                  sh[c] <= {1'b0, sh[c][DATA_WIDTH-1:1]};
                end else begin
                  sh[c] <= {sh[c][DATA_WIDTH-2:0], 1'b0};
                end
              end
            end
          end
          GAP: begin
            if (gap_done) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    s_out = '0;
    if (state == SHIFT) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (LSB_FIRST != 0) begin
          s_out[c] = sh[c][0];
        end else begin
          s_out[c] = sh[c][DATA_WIDTH-1];
        end
      end
    end
  end

  assign s_load_out    = (state == SHIFT) && (bit_cnt == '0);
  assign s_busy_out    = (state != IDLE);
  assign par_ready_out = !buf_full;

endmodule

// File: tb/tb_multi_ch_frame_serializer.sv
// Bench for multi_ch_frame_serializer: three configurations driven
// together, checked against a frame-level model plus literal sequences.
module tb_multi_ch_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [2:0]  vin = '0;
  logic [31:0] da = '0;
  logic [7:0]  db = '0;
  logic [7:0]  dc = '0;

  logic       ra, rb, rc;
  logic [3:0] soa;
  logic       sob, soc;
  logic       la, lb, lc;
  logic       ba, bb, bc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_ch_frame_serializer #(
    .DATA_WIDTH(8), .NUM_CH(4), .LSB_FIRST(1), .GAP_BITS(0)
  ) u_a (
    .serclk(clk), .reset_n(rst_n), .enable(en),
    .par_data_in(da), .par_valid_in(vin[0]),
    .par_ready_out(ra), .s_out(soa),
    .s_load_out(la), .s_busy_out(ba)
  );

  multi_ch_frame_serializer #(
    .DATA_WIDTH(8), .NUM_CH(1), .LSB_FIRST(0), .GAP_BITS(0)
  ) u_b (
    .serclk(clk), .reset_n(rst_n), .enable(en),
    .par_data_in(db), .par_valid_in(vin[1]),
    .par_ready_out(rb), .s_out(sob),
    .s_load_out(lb), .s_busy_out(bb)
  );

  multi_ch_frame_serializer #(
    .DATA_WIDTH(8), .NUM_CH(1), .LSB_FIRST(1), .GAP_BITS(3)
  ) u_c (
    .serclk(clk), .reset_n(rst_n), .enable(en),
    .par_data_in(dc), .par_valid_in(vin[2]),
    .par_ready_out(rc), .s_out(soc),
    .s_load_out(lc), .s_busy_out(bc)
  );

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int lsbf(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int gapb(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic logic [31:0] din(input int i);
    if (i == 0) return da;
    if (i == 1) return {24'h0, db};
    return {24'h0, dc};
  endfunction

  // Model: mode 0 idle, 1 sending word m_cur bit m_idx, 2 in gap
  logic [31:0] m_hold [3];
  logic [31:0] m_cur  [3];
  logic        m_full [3];
  int          m_mode [3];
  int          m_idx  [3];
  int          m_gap  [3];

  logic [2:0] m_ready;
  always_comb begin
    m_ready = '0;
    for (int i = 0; i < 3; i++) m_ready[i] = !m_full[i];
  end

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] h, cu;
    logic        f, go;
    int          md, ix, gp;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_hold[i] <= '0;
        m_cur[i]  <= '0;
        m_full[i] <= 1'b0;
        m_mode[i] <= 0;
        m_idx[i]  <= 0;
        m_gap[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        h = m_hold[i]; cu = m_cur[i]; f = m_full[i];
        md = m_mode[i]; ix = m_idx[i]; gp = m_gap[i];
        go = 1'b0;
        if (en) begin
          if (md == 0) begin
            go = f;
          end else if (md == 1) begin
            if (ix < 7) ix = ix + 1;
            else if (gapb(i) > 0) begin md = 2; gp = 0; end
            else if (f) go = 1'b1;
            else md = 0;
          end else begin
            if (gp < gapb(i) - 1) gp = gp + 1;
            else if (f) go = 1'b1;
            else md = 0;
          end
        end
        if (vin[i] && !m_full[i]) begin
          h = din(i); f = 1'b1;
        end else if (go) begin
          cu = h; f = 1'b0; md = 1; ix = 0;
        end
        m_hold[i] <= h; m_cur[i] <= cu; m_full[i] <= f;
        m_mode[i] <= md; m_idx[i] <= ix; m_gap[i] <= gp;
      end
    end
  end

  function automatic logic [31:0] e_sout(input int i);
    logic [31:0] e;
    int b;
    e = '0;
    if (m_mode[i] == 1) begin
      b = (lsbf(i) != 0) ? m_idx[i] : 7 - m_idx[i];
      for (int c = 0; c < nch(i); c++) e[c] = m_cur[i][c*8 + b];
    end
    return e;
  endfunction

  function automatic logic [31:0] a_sout(input int i);
    if (i == 0) return {28'h0, soa};
    if (i == 1) return {31'h0, sob};
    return {31'h0, soc};
  endfunction

  function automatic logic [3:0] a_flags(input int i);
    if (i == 0) return {1'b0, ra, la, ba};
    if (i == 1) return {1'b0, rb, lb, bb};
    return {1'b0, rc, lc, bc};
  endfunction

  task automatic check(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got %h want %h",
               nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] fl;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        fl = a_flags(i);
        check("s_out", i, a_sout(i), e_sout(i));
        check("load", i, {31'h0, fl[1]},
              {31'h0, m_mode[i] == 1 && m_idx[i] == 0});
        check("busy", i, {31'h0, fl[0]}, {31'h0, m_mode[i] != 0});
        check("ready", i, {31'h0, fl[2]}, {31'h0, !m_full[i]});
      end
    end
  end

  task automatic offer(input logic [2:0] m, input logic [31:0] a,
                       input logic [7:0] b, input logic [7:0] c);
    logic [2:0] acc;
    da = a; db = b; dc = c; vin = m;
    for (int k = 0; k < 100 && vin != 0; k++) begin
      acc = vin & m_ready;
      @(negedge clk);
      vin = vin & ~acc;
    end
    if (vin != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL offer_timeout got %b want 000", vin);
      vin = '0;
    end
  endtask

  logic [31:0] cap_a, cap_b, cap_c, cap_l, cap_y;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sout", 0, {28'h0, soa}, 32'h0);
    check("rst_ready", 0, {31'h0, ra}, 32'h1);
    check("rst_busy", 1, {31'h0, bb}, 32'h0);
    check("rst_load", 2, {31'h0, lc}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 on c (0x0F LSB), T2 on b (0x0F MSB), T5 on a
    offer(3'b111, 32'h08040201, 8'h0F, 8'h0F);
    cap_a = '0; cap_b = '0; cap_c = '0; cap_l = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) cap_a[c*8 + k] = soa[c];
      cap_b[k] = sob; cap_c[k] = soc; cap_l[k] = la;
    end
    check("t5_lanes", 0, cap_a, 32'h08040201);
    check("t5_load", 0, cap_l, 32'h01);
    check("t2_msb", 1, cap_b, 32'hF0);
    check("t1_lsb", 2, cap_c, 32'h0F);
    @(negedge clk);
    check("t2_idle_busy", 1, {31'h0, bb}, 32'h0);
    check("t2_idle_sout", 1, {31'h0, sob}, 32'h0);
    check("t1_gap_busy", 2, {31'h0, bc}, 32'h1);
    repeat (10) @(negedge clk);

    // T3: back-to-back with no gap
    cap_a = '0; cap_l = '0;
    fork
      begin
        offer(3'b001, 32'hA5, 8'h0, 8'h0);
        offer(3'b001, 32'h3C, 8'h0, 8'h0);
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          cap_a[k] = soa[0]; cap_l[k] = la;
        end
      end
    join
    check("t3_bits", 0, cap_a, 32'h3CA5);
    check("t3_load", 0, cap_l, 32'h0101);
    repeat (5) @(negedge clk);

    // T4: two frames with a three bit-time gap
    cap_c = '0; cap_l = '0; cap_y = '0;
    fork
      begin
        offer(3'b100, 32'h0, 8'h0, 8'h81);
        offer(3'b100, 32'h0, 8'h0, 8'h42);
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 19; k++) begin
          @(negedge clk);
          cap_c[k] = soc; cap_l[k] = lc; cap_y[k] = bc;
        end
      end
    join
    check("t4_bits", 2, cap_c, 32'h21081);
    check("t4_load", 2, cap_l, 32'h801);
    check("t4_busy", 2, cap_y, 32'h7FFFF);
    repeat (8) @(negedge clk);

    // T6: pause at bit 3, then reset at bit 4
    cap_a = '0; cap_y = '0;
    offer(3'b001, 32'h2B, 8'h0, 8'h0);
    @(negedge clk);
    cap_a[0] = soa[0]; cap_y[0] = ba;
    offer(3'b001, 32'hFF, 8'h0, 8'h0);
    cap_a[1] = soa[0]; cap_y[1] = ba;
    for (int k = 2; k < 10; k++) begin
      @(negedge clk);
      cap_a[k] = soa[0]; cap_y[k] = ba;
      if (k == 3) en = 1'b0;
      if (k == 8) en = 1'b1;
    end
    check("t6_pause_bits", 0, cap_a, 32'h1FB);
    check("t6_pause_busy", 0, cap_y, 32'h3FF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sout", 0, {28'h0, soa}, 32'h0);
    check("t6_rst_ready", 0, {31'h0, ra}, 32'h1);
    check("t6_rst_busy", 0, {31'h0, ba}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_idle", 0, {30'h0, ba, la}, 32'h0);
    cap_a = '0; cap_l = '0;
    offer(3'b001, 32'h55, 8'h0, 8'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cap_a[k] = soa[0]; cap_l[k] = la;
    end
    check("t6_restart_bits", 0, cap_a, 32'h55);
    check("t6_restart_load", 0, cap_l, 32'h01);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
